// File: rtl/cpu_pkg.sv
// Shared definitions for the control-phase sequencer: state encoding and
// the opcode field layout used to recognise the STP instruction.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC1,
    S_EXEC2,
    S_PAUSE,
    S_HALT
  } state_t;

  localparam logic [4:0] OPC_STP = 5'b00000;
  localparam int         OPC_MSB = 15;
  localparam int         OPC_LSB = 11;

  function automatic logic is_stp(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_STP;
  endfunction

endpackage

// File: rtl/cycle_sequencer_sat_counter.sv
// Saturating up-counter: advances by one per cycle with inc high and
// parks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cycle_sequencer.sv
// Fetch/load/execute phase sequencer feeding the instruction decoder, with
// STP halt, single-step pause handshake and saturating activity counters.
module cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [15:0]      instr,
  input  logic             extra1,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             fe,
  output logic             e1,
  output logic             e2,
  output logic [15:0]      ir,
  output logic             busy,
  output logic             paused,
  output logic             halted,
  output logic             step_ack,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        fe_q, e1_q, e2_q, busy_q, paused_q, halted_q;
  logic        instr_done;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    instr_done = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        ir_d    = instr;
        state_d = S_EXEC1;
      end
      S_EXEC1: begin
        // STP wins over a second-execute request.
        if (is_stp(ir_q)) begin
          instr_done = 1'b1;
          state_d    = S_HALT;
        end else if (extra1) begin
          state_d = S_EXEC2;
        end else begin
          instr_done = 1'b1;
          state_d    = step_mode ? S_PAUSE : S_FETCH;
        end
      end
      S_EXEC2: begin
        instr_done = 1'b1;
        state_d    = step_mode ? S_PAUSE : S_FETCH;
      end
      S_PAUSE: if (step_req) state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      ir_q     <= 16'h0000;
      fe_q     <= 1'b0;
      e1_q     <= 1'b0;
      e2_q     <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      fe_q     <= (state_d == S_FETCH);
      e1_q     <= (state_d == S_EXEC1);
      e2_q     <= (state_d == S_EXEC2);
      busy_q   <= (state_d == S_FETCH) || (state_d == S_LOAD) ||
                  (state_d == S_EXEC1) || (state_d == S_EXEC2);
      paused_q <= (state_d == S_PAUSE);
      halted_q <= (state_d == S_HALT);
    end
  end

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (instr_done),
    .count (instr_count)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (busy_q),
    .count (cycle_count)
  );

  assign fe       = fe_q;
  assign e1       = e1_q;
  assign e2       = e2_q;
  assign ir       = ir_q;
  assign busy     = busy_q;
  assign paused   = paused_q;
  assign halted   = halted_q;
  assign step_ack = (state_q == S_PAUSE) && step_req;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench: per-cycle expectation records are generated from an
// instruction-level model, then applied to a 16-bit and a 4-bit counter DUT.
module tb_cycle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst, start, extra1, step_mode, step_req;
  logic [15:0] instr;

  logic        a_fe, a_e1, a_e2, a_busy, a_paused, a_halted, a_ack;
  logic [15:0] a_ir, a_ic, a_cc;
  logic        b_fe, b_e1, b_e2, b_busy, b_paused, b_halted, b_ack;
  logic [15:0] b_ir;
  logic [3:0]  b_ic, b_cc;

  cycle_sequencer #(.CNT_W(16)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start), .instr(instr), .extra1(extra1),
    .step_mode(step_mode), .step_req(step_req), .fe(a_fe), .e1(a_e1), .e2(a_e2),
    .ir(a_ir), .busy(a_busy), .paused(a_paused), .halted(a_halted),
    .step_ack(a_ack), .instr_count(a_ic), .cycle_count(a_cc)
  );

  cycle_sequencer #(.CNT_W(4)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start), .instr(instr), .extra1(extra1),
    .step_mode(step_mode), .step_req(step_req), .fe(b_fe), .e1(b_e1), .e2(b_e2),
    .ir(b_ir), .busy(b_busy), .paused(b_paused), .halted(b_halted),
    .step_ack(b_ack), .instr_count(b_ic), .cycle_count(b_cc)
  );

  // Strobe vector bits: fe, e1, e2, busy, paused, halted, step_ack
  localparam logic [6:0] ST_I  = 7'b0000000;
  localparam logic [6:0] ST_F  = 7'b1001000;
  localparam logic [6:0] ST_L  = 7'b0001000;
  localparam logic [6:0] ST_E1 = 7'b0101000;
  localparam logic [6:0] ST_E2 = 7'b0011000;
  localparam logic [6:0] ST_P  = 7'b0000100;
  localparam logic [6:0] ST_PA = 7'b0000101;
  localparam logic [6:0] ST_H  = 7'b0000010;

  typedef struct {
    logic        start;
    logic [15:0] instr;
    logic        extra1;
    logic        step_mode;
    logic        step_req;
    logic [6:0]  strb;
    logic [15:0] ir;
    int          ic;
    int          cc;
  } vec_t;

  vec_t        q[$];
  logic [15:0] m_ir;
  int          m_ic, m_cc, cyc;
  logic        last_ack;
  int          n_assert, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic add(input logic st, input logic [15:0] ins, input logic x1,
                     input logic sm, input logic sr, input logic [6:0] s);
    vec_t v;
    v.start = st; v.instr = ins; v.extra1 = x1; v.step_mode = sm; v.step_req = sr;
    v.strb = s; v.ir = m_ir; v.ic = m_ic; v.cc = m_cc;
    q.push_back(v);
    if (s[3]) m_cc++;
  endtask

  // One instruction: F, L, E1, optional E2, optional pause with handshake.
  task automatic add_instr(input logic [15:0] w, input logic x1, input logic sm,
                           input int waits, input logic sm_p);
    add(rb(), 16'($urandom), rb(), sm, last_ack ? 1'b1 : rb(), ST_F);
    last_ack = 1'b0;
    add(rb(), w, rb(), sm, rb(), ST_L);
    m_ir = w;
    add(rb(), 16'($urandom), x1, sm, rb(), ST_E1);
    if (w[15:11] == 5'b00000) begin
      m_ic++;
      return;
    end
    if (x1) add(rb(), 16'($urandom), rb(), sm, rb(), ST_E2);
    m_ic++;
    if (sm) begin
      for (int i = 0; i < waits; i++) add(rb(), 16'($urandom), rb(), sm_p, 1'b0, ST_P);
      add(rb(), 16'($urandom), rb(), sm_p, 1'b1, ST_PA);
      last_ack = 1'b1;
    end
  endtask

  task automatic run_q();
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      start = v.start; instr = v.instr; extra1 = v.extra1;
      step_mode = v.step_mode; step_req = v.step_req;
      #1;
      check("strobes16", 64'({a_fe, a_e1, a_e2, a_busy, a_paused, a_halted, a_ack}), 64'(v.strb));
      check("ir16", 64'(a_ir), 64'(v.ir));
      check("instr_count16", 64'(a_ic), 64'(sat(v.ic, 65535)));
      check("cycle_count16", 64'(a_cc), 64'(sat(v.cc, 65535)));
      check("strobes4", 64'({b_fe, b_e1, b_e2, b_busy, b_paused, b_halted, b_ack}), 64'(v.strb));
      check("counts4", 64'({b_ic, b_cc}), 64'({4'(sat(v.ic, 15)), 4'(sat(v.cc, 15))}));
      $display("cyc %0d strb=%b ir=%h ic=%0d cc=%0d", cyc, v.strb, v.ir, v.ic, v.cc);
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({a_fe, a_e1, a_e2, a_busy, a_paused, a_halted, a_ack, a_ir, a_ic, a_cc}), 64'(0));
    check(name, 64'({b_fe, b_e1, b_e2, b_busy, b_paused, b_halted, b_ack, b_ir, b_ic, b_cc}), 64'(0));
  endtask

  task automatic model_reset();
    m_ir = 16'h0000; m_ic = 0; m_cc = 0; last_ack = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    n_assert = 0; n_fail = 0; cyc = 0;
    n_rst = 1'b0; start = 1'b0; instr = 16'h0; extra1 = 1'b0;
    step_mode = 1'b0; step_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed: idle hold, ADR, LDA, step mode, then a run long enough to saturate CNT_W=4
    add(1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, ST_I);
    add(1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, ST_I);
    add(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, ST_I);
    add_instr(16'h0800, 1'b0, 1'b0, 0, 1'b0);
    add_instr(16'hC005, 1'b1, 1'b0, 0, 1'b0);
    add_instr(16'h0800, 1'b0, 1'b1, 2, 1'b0);
    add_instr(16'h0800, 1'b0, 1'b1, 0, 1'b1);
    for (int i = 0; i < 20; i++) add_instr(16'h0800, 1'b0, 1'b0, 0, 1'b0);
    run_q();

    // Reset asserted while e2 is high
    add(1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, ST_F);
    add(1'b0, 16'hC005, 1'b0, 1'b0, 1'b0, ST_L);
    m_ir = 16'hC005;
    add(1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, ST_E1);
    run_q();
    start = 1'b0;
    #1;
    check("e2_before_reset", 64'({a_e2, b_e2}), 64'(2'b11));
    n_rst = 1'b0;
    #1;
    check_all_zero("reset_mid_e2");
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) add(1'b0, 16'($urandom), rb(), rb(), rb(), ST_I);
    add(1'b1, 16'($urandom), rb(), rb(), rb(), ST_I);

    // Randomized instruction stream, then STP (with extra1 set) and sticky halt
    for (int i = 0; i < 40; i++) begin
      do w = 16'($urandom); while (w[15:11] == 5'b00000);
      add_instr(w, rb(), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), rb());
    end
    add_instr({5'b00000, 11'($urandom)}, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) add(1'(i % 2 == 0), 16'($urandom), rb(), rb(), rb(), ST_H);
    run_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
